// File: rtl/gf180mcu_osu_sc_9t_tbus_rx.sv
// gf180mcu_osu_sc_9t_tbus_rx
// Receiving end of a shared tri-state bus built from tbuf driver cells. A round-robin arbiter
// picks one requesting driver, enables it for SETTLE cycles, samples the bus into a holding
// register and then keeps every driver off for TURN dead cycles (break-before-make).
//
// Ports:
//   clk     in   1           clock, all state changes on posedge
//   rst     in   1           asynchronous reset, active-high
//   req     in   N           per-driver request, level, held until ack
//   bus     in   WIDTH       resolved tri-state bus value, only used on the sample edge
//   en      out  N           registered driver enables, at most one bit set
//   en_bar  out  N           registered complement of en
//   ack     out  N           one-cycle pulse to the driver whose data was captured
//   data    out  WIDTH       last captured bus value, held between transfers
//   valid   out  1           one-cycle pulse coincident with the data update
//   src     out  $clog2(N)   index of the driver that produced data, held with data
module gf180mcu_osu_sc_9t_tbus_rx #(
    parameter int unsigned N      = 4,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned TURN   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [WIDTH-1:0]     bus,
    output logic [N-1:0]         en,
    output logic [N-1:0]         en_bar,
    output logic [N-1:0]         ack,
    output logic [WIDTH-1:0]     data,
    output logic                 valid,
    output logic [$clog2(N)-1:0] src
);

    localparam int unsigned SW = $clog2(N);
    localparam logic [SW:0] NW = (SW+1)'(N);
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSample,
        StTurn
    } state_e;

    state_e        state_q;
    logic [2:0]    cnt_q;
    logic [SW-1:0] gnt_q;
    logic [SW-1:0] rr_ptr_q;

    logic          req_any;
    logic [SW-1:0] gnt_idx;
    logic [N-1:0]  gnt_oh;
    logic [N-1:0]  gnt_q_oh;
    logic [SW:0]   idx;

    // Round-robin search: first set request at or after rr_ptr, wrapping modulo N.
    always_comb begin
        req_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = {1'b0, rr_ptr_q} + (SW+1)'(i);
            if (idx >= NW) begin
                idx = idx - NW;
            end
            if (!req_any && req[idx[SW-1:0]]) begin
                req_any = 1'b1;
                gnt_idx = idx[SW-1:0];
            end
        end
    end

    always_comb begin
        gnt_oh           = '0;
        gnt_oh[gnt_idx]  = 1'b1;
        gnt_q_oh         = '0;
        gnt_q_oh[gnt_q]  = 1'b1;
    end

    // Reset drops every enable at once, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            en       <= '0;
            en_bar   <= '1;
            ack      <= '0;
            valid    <= 1'b0;
            data     <= '0;
            src      <= '0;
        end else begin
            valid <= 1'b0;
            ack   <= '0;
            unique case (state_q)
                StIdle: begin
                    if (req_any) begin
                        en      <= gnt_oh;
                        en_bar  <= ~gnt_oh;
                        gnt_q   <= gnt_idx;
                        cnt_q   <= 3'(SETTLE);
                        state_q <= StDrive;
                    end
                end
                StDrive: begin
                    // A driver withdrawing its request aborts the transfer with no capture.
                    if (!req[gnt_q]) begin
                        en      <= '0;
                        en_bar  <= '1;
                        cnt_q   <= 3'(TURN);
                        state_q <= StTurn;
                    end else if (cnt_q == 3'd1) begin
                        state_q <= StSample;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StSample: begin
                    data     <= bus;
                    src      <= gnt_q;
                    valid    <= 1'b1;
                    ack      <= gnt_q_oh;
                    en       <= '0;
                    en_bar   <= '1;
                    rr_ptr_q <= (gnt_q == LAST) ? '0 : gnt_q + 1'b1;
                    cnt_q    <= 3'(TURN);
                    state_q  <= StTurn;
                end
                StTurn: begin
                    // Requests are ignored here so no grant lands right after an enable falls.
                    if (cnt_q == 3'd1) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_tbus_rx.sv
// Directed and random bench for gf180mcu_osu_sc_9t_tbus_rx with N=4, WIDTH=8, SETTLE=1, TURN=1.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_gf180mcu_osu_sc_9t_tbus_rx;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [W-1:0] bus;
    logic [N-1:0] en;
    logic [N-1:0] en_bar;
    logic [N-1:0] ack;
    logic [W-1:0] data;
    logic         valid;
    logic [1:0]   src;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [N-1:0] en_p1 = '0;
    logic [N-1:0] en_p2 = '0;
    logic [W-1:0] bus_edge = '0;
    logic [N-1:0] one = 4'b0001;
    int           n_valid = 0;
    int           n;

    gf180mcu_osu_sc_9t_tbus_rx #(
        .N      (4),
        .WIDTH  (8),
        .SETTLE (1),
        .TURN   (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .bus    (bus),
        .en     (en),
        .en_bar (en_bar),
        .ack    (ack),
        .data   (data),
        .valid  (valid),
        .src    (src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count falling edges until valid is seen, giving up after budget edges.
    task automatic wait_valid(input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!valid && cycles < budget);
    endtask

    // Bus value present at each rising edge, i.e. what a sample edge would capture.
    always @(posedge clk) bus_edge <= bus;

    // Every-cycle invariants on the enable pair.
    always @(negedge clk) begin
        check("inv_en_bar", en_bar ^ en, 4'hF);
        check("inv_onehot", ($countones(en) <= 1), 1);
        if (|(en_p2 & ~en_p1)) begin
            check("inv_no_rise", en & ~en_p1, 0);
        end
        en_p2 <= en_p1;
        en_p1 <= en;
    end

    initial begin
        rst = 1'b1;
        req = '0;
        bus = '0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check("rst_en", en, 4'h0);
        check("rst_en_bar", en_bar, 4'hF);
        check("rst_ack", ack, 4'h0);
        check("rst_valid", valid, 0);
        check("rst_data", data, 8'h00);
        check("rst_src", src, 0);

        // Single request from driver 0
        rst = 1'b0;
        req = 4'b0001;
        bus = 8'hA5;
        @(negedge clk);
        check("t1_en_c1", en, 4'b0001);
        check("t1_en_bar_c1", en_bar, 4'b1110);
        check("t1_valid_c1", valid, 0);
        @(negedge clk);
        check("t1_en_c2", en, 4'b0001);
        check("t1_valid_c2", valid, 0);
        @(negedge clk);
        check("t1_valid", valid, 1);
        check("t1_data", data, 8'hA5);
        check("t1_src", src, 0);
        check("t1_ack", ack, 4'b0001);
        check("t1_en_off", en, 4'b0000);
        req = 4'b0000;
        bus = 8'hFF;
        @(negedge clk);
        check("t1_valid_pulse", valid, 0);
        check("t1_ack_pulse", ack, 4'b0000);
        check("t1_data_hold", data, 8'hA5);

        // Driver 2 withdraws one cycle after its grant: abort
        req = 4'b0100;
        bus = 8'h3C;
        @(negedge clk);
        check("ab_en_grant", en, 4'b0100);
        check("ab_en_bar_grant", en_bar, 4'b1011);
        req = 4'b0000;
        @(negedge clk);
        check("ab_en_off", en, 4'b0000);
        check("ab_valid", valid, 0);
        check("ab_ack", ack, 4'b0000);
        check("ab_data_hold", data, 8'hA5);
        @(negedge clk);
        check("ab_en_turn", en, 4'b0000);
        check("ab_valid_turn", valid, 0);
        check("ab_data_hold2", data, 8'hA5);

        // Transfer from driver 2 moves the pointer to 3
        req = 4'b0100;
        bus = 8'h5A;
        wait_valid(10, n);
        check("d2_latency", n, 3);
        check("d2_src", src, 2);
        check("d2_data", data, 8'h5A);
        check("d2_ack", ack, 4'b0100);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);

        // Pointer at 3 with requests 3 and 0: grant 3, then wrap to 0
        req = 4'b1001;
        bus = 8'hC3;
        @(negedge clk);
        check("wr_en_first", en, 4'b1000);
        wait_valid(10, n);
        check("wr_lat3", n, 2);
        check("wr_src3", src, 3);
        check("wr_ack3", ack, 4'b1000);
        check("wr_data3", data, 8'hC3);
        req = 4'b0001;
        bus = 8'h96;
        wait_valid(10, n);
        check("wr_gap0", n, 4);
        check("wr_src0", src, 0);
        check("wr_ack0", ack, 4'b0001);
        check("wr_data0", data, 8'h96);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);

        // Reset pulse mid-DRIVE with driver 2 enabled
        req = 4'b0100;
        bus = 8'h77;
        @(negedge clk);
        check("mr_en_grant", en, 4'b0100);
        #2;
        rst = 1'b1;
        #1;
        check("mr_en_async", en, 4'b0000);
        check("mr_en_bar_async", en_bar, 4'hF);
        check("mr_valid_async", valid, 0);
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mr_data", data, 8'h00);
        check("mr_src", src, 0);
        check("mr_valid", valid, 0);
        check("mr_en", en, 4'b0000);

        // All requests held: grants rotate 0,1,2,3,0 every 4 cycles
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            bus = 8'h10 + 8'(k);
            wait_valid(20, n);
            check((k == 0) ? "rr_latency" : "rr_spacing", n, (k == 0) ? 3 : 4);
            check("rr_src", src, k % 4);
            check("rr_data", data, 8'h10 + 8'(k));
            check("rr_ack", ack, one << (k % 4));
        end
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);

        // Random requesters and bus values
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (valid) begin
                n_valid++;
                check("rnd_data", data, bus_edge);
                check("rnd_ack", ack, one << src);
                check("rnd_src_was_en", en_p1[src], 1);
            end
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(3) == 0) req[i] = 1'b1;
                end else if ($urandom_range(63) == 0) begin
                    req[i] = 1'b0;
                end
            end
            bus = 8'($urandom);
        end
        check("rnd_activity", (n_valid >= 500), 1);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
